// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus: MEM/WB writeback controls plus decode read ports.
// Latency: pure signal bundle, no storage.
// Backpressure: none; the writeback stage never stalls on the register file.
// Ports: wb_* writeback controls/sources, rd_addr*/rd_data* read ports,
//        wb_data/wb_we forwarding view, halted and wr_count status.
interface wb_regfile_if #(
  parameter int CNT_W = 16
);
  logic             wb_RegWrite;
  logic             wb_MemtoReg;
  logic [3:0]       wb_RegRd;
  logic [3:0]       wb_Opcode;
  logic [15:0]      wb_alu_data;
  logic [15:0]      wb_lw_data;
  logic [15:0]      wb_pc_inc;
  logic [7:0]       wb_imm8;
  logic [3:0]       rd_addr1;
  logic [3:0]       rd_addr2;
  logic [15:0]      rd_data1;
  logic [15:0]      rd_data2;
  logic [15:0]      wb_data;
  logic             wb_we;
  logic             halted;
  logic [CNT_W-1:0] wr_count;

  // Pipeline side: drives writeback and read addresses, observes results.
  modport master (
    output wb_RegWrite, wb_MemtoReg, wb_RegRd, wb_Opcode,
    output wb_alu_data, wb_lw_data, wb_pc_inc, wb_imm8,
    output rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, wb_data, wb_we, halted, wr_count
  );

  // Register file side.
  modport slave (
    input  wb_RegWrite, wb_MemtoReg, wb_RegRd, wb_Opcode,
    input  wb_alu_data, wb_lw_data, wb_pc_inc, wb_imm8,
    input  rd_addr1, rd_addr2,
    output rd_data1, rd_data2, wb_data, wb_we, halted, wr_count
  );
endinterface

// File: rtl/wb_regfile.sv
// 16x16 register file with writeback mux, HLT state and saturating retired-write counter.
// Latency: wb_* -> wb_data/wb_we combinational; storage, counter and halted one cycle.
// Backpressure: none; once HALTED all writes are dropped until reset.
// Ports: clk, rst (synchronous, active low), bus (wb_regfile_if.slave).
// Option: define WB_BYPASS_EN to forward a same-cycle write onto the read ports.
module wb_regfile #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  localparam logic [3:0] OP_LLB = 4'hA;
  localparam logic [3:0] OP_LHB = 4'hB;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_regs [16];
  logic [CNT_W-1:0] r_wr_count;

  logic [15:0]      w_rd_cur;
  logic [15:0]      w_wb_data;
  logic [15:0]      w_rd1;
  logic [15:0]      w_rd2;
  logic             w_halted;
  logic             w_we;

  assign w_halted = (r_state == ST_HALTED);
  // rst is active low, so it also gates the enable while reset is held.
  assign w_we     = bus.wb_RegWrite & ~w_halted & rst;
  // LLB/LHB merge the immediate into the current contents of the destination.
  assign w_rd_cur = r_regs[bus.wb_RegRd];

  always_comb begin
    w_wb_data = bus.wb_alu_data;
    if (bus.wb_MemtoReg) begin
      w_wb_data = bus.wb_lw_data;
    end else if (bus.wb_Opcode == OP_LLB) begin
      w_wb_data = {w_rd_cur[15:8], bus.wb_imm8};
    end else if (bus.wb_Opcode == OP_LHB) begin
      w_wb_data = {bus.wb_imm8, w_rd_cur[7:0]};
    end else if (bus.wb_Opcode == OP_PCS) begin
      w_wb_data = bus.wb_pc_inc;
    end
  end

  // HLT with RegWrite in the same cycle still writes: the state only
  // changes at the edge, and w_we looks at the current state.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_RUN) && (bus.wb_Opcode == OP_HLT)) begin
      w_state_nxt = ST_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we && (bus.wb_RegRd != 4'd0)) begin
      r_regs[bus.wb_RegRd] <= w_wb_data;
    end
  end

  // Writes to R0 are discarded but still count as retired.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_count <= '0;
    end else if (w_we && (r_wr_count != {CNT_W{1'b1}})) begin
      r_wr_count <= r_wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_rd1 = (bus.rd_addr1 == 4'd0) ? 16'h0000 : r_regs[bus.rd_addr1];
`ifdef WB_BYPASS_EN
    if (w_we && (bus.wb_RegRd == bus.rd_addr1) && (bus.rd_addr1 != 4'd0)) begin
      w_rd1 = w_wb_data;
    end
`endif
  end

  always_comb begin
    w_rd2 = (bus.rd_addr2 == 4'd0) ? 16'h0000 : r_regs[bus.rd_addr2];
`ifdef WB_BYPASS_EN
    if (w_we && (bus.wb_RegRd == bus.rd_addr2) && (bus.rd_addr2 != 4'd0)) begin
      w_rd2 = w_wb_data;
    end
`endif
  end

  assign bus.rd_data1 = w_rd1;
  assign bus.rd_data2 = w_rd2;
  assign bus.wb_data  = w_wb_data;
  assign bus.wb_we    = w_we;
  assign bus.halted   = w_halted;
  assign bus.wr_count = r_wr_count;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, giving the width of the retired-write counter.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its posedge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-low reset, sampled on posedge clk.
REQ-004 SHALL have port wb_RegWrite, input, 1: register-write control from the MEM/WB stage.
REQ-005 SHALL have port wb_MemtoReg, input, 1: selects load data for writeback.
REQ-006 SHALL have port wb_RegRd, input, 4: destination register.
REQ-007 SHALL have port wb_Opcode, input, 4: opcode of the instruction in WB.
REQ-008 SHALL have ports wb_alu_data, wb_lw_data and wb_pc_inc, each input, 16: the three writeback sources.
REQ-009 SHALL have port wb_imm8, input, 8: immediate for LLB/LHB.
REQ-010 SHALL have ports rd_addr1 and rd_addr2, each input, 4: decode-stage read addresses.
REQ-011 SHALL have ports rd_data1 and rd_data2, each output, 16: read data.
REQ-012 SHALL have port wb_data, output, 16: selected writeback value, used by forwarding.
REQ-013 SHALL have port wb_we, output, 1: effective write enable this cycle.
REQ-014 SHALL have port halted, output, 1: processor halted.
REQ-015 SHALL have port wr_count, output, CNT_W: number of retired register writes.

Function
REQ-016 SHALL contain 16 x 16-bit registers; R0 reads 0 always, and writes to R0 are discarded, though still counted if wb_we=1.
REQ-017 SHALL select wb_data combinationally, in priority order:
- wb_MemtoReg=1 -> wb_lw_data
- opcode 1010 (LLB) -> {R[Rd][15:8], wb_imm8}
- opcode 1011 (LHB) -> {wb_imm8, R[Rd][7:0]}
- opcode 1110 (PCS) -> wb_pc_inc
- otherwise -> wb_alu_data
REQ-018 SHALL drive wb_we = wb_RegWrite & ~halted & rst.
REQ-019 SHALL write wb_data into R[wb_RegRd] on the posedge when wb_we=1; the write is visible in storage the next cycle.
REQ-020 SHALL make reads combinational from storage, with the bypass behaviour set by REQ-030/031.
REQ-021 SHALL implement a two-state FSM:
- RUN -> HALTED when wb_Opcode=1111 in RUN; the transition takes effect at the next posedge.
- HALTED is sticky and is left only by reset.
- halted=1 iff state is HALTED.
REQ-022 SHALL honour wb_RegWrite in the same cycle that HLT is in WB; blocking begins the following cycle.
REQ-023 SHALL, while HALTED, perform no register writes and hold the counter; reads still function.
REQ-024 SHALL increment wr_count by 1 on each posedge with wb_we=1, and saturate at all-ones with no wrap.
REQ-025 SHALL have zero latency from wb_* inputs to wb_data/wb_we, and one cycle to storage, the counter and halted.

Reset
REQ-026 SHALL, on posedge clk with rst=0, clear all 16 registers to 0, set state to RUN, and set wr_count to 0.
REQ-027 SHALL give priority to reset over a simultaneous write or HLT, and suppress wb_we while rst=0.
REQ-028 SHALL, on reset asserted mid-halt, return to RUN at the next posedge.
REQ-029 SHALL produce these outputs one cycle after reset: halted=0, wr_count=0, rd_data*=0.

Configuration
REQ-030 SHALL, when WB_BYPASS_EN is defined, return wb_data on rd_dataN when wb_we=1, wb_RegRd=rd_addrN and rd_addrN!=0 (write-before-read).
REQ-031 SHALL, when WB_BYPASS_EN is undefined, return only stored values on reads, so a same-cycle write is visible the next cycle.

Verification
REQ-032 SHALL cover: after reset, write R3 with ALU data 0x1234, read R3 next cycle -> rd_data1=0x1234 and wr_count=1.
REQ-033 SHALL cover: R5=0xABCD, then LLB imm8=0x5A to R5 -> R5=0xAB5A; then LHB imm8=0x12 -> R5=0x125A.
REQ-034 SHALL cover: write R0 with 0xFFFF -> rd_data1 for addr 0 stays 0x0000, and wr_count increments.
REQ-035 SHALL cover: with WB_BYPASS_EN, write R7=0x0042 while reading R7 -> rd_data2=0x0042 in the same cycle; without it -> old value, then 0x0042 next cycle.
REQ-036 SHALL cover: HLT in WB with RegWrite=1 to R2 -> the write occurs and halted=1 next cycle; later writes are ignored and wr_count is frozen; rst=0 -> halted=0.
REQ-037 SHALL cover: with CNT_W=4, apply 17 writes -> wr_count=0xF (saturated).
